// File: rtl/rot_addr_ctrl_if.sv
// Rotary encoder/switch inputs and address outputs of the rotary debug-address controller.
interface rot_addr_ctrl_if #(
  parameter int CHANNELS   = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 5
);
  logic [SEL_WIDTH-1:0]           sel;
  logic                           rot_a;
  logic                           rot_b;
  logic                           rot_ctr;
  logic                           fast;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [CHANNELS*ADDR_WIDTH-1:0] addr_all;
  logic                           inc_pulse;
  logic                           dec_pulse;

  modport master (
    output sel, rot_a, rot_b, rot_ctr, fast,
    input  addr, addr_all, inc_pulse, dec_pulse
  );

  modport slave (
    input  sel, rot_a, rot_b, rot_ctr, fast,
    output addr, addr_all, inc_pulse, dec_pulse
  );
endinterface

// File: rtl/rot_addr_ctrl.sv
// Multi-channel debug-address registers stepped by a quadrature rotary encoder,
// with fast stepping, wrap/saturate arithmetic and clear-on-press.
module rot_addr_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int ADDR_MAX   = 31,
  parameter int WRAP       = 1,
  parameter int FAST_SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst,
  rot_addr_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] MAX_X     = (ADDR_WIDTH+1)'(ADDR_MAX);
  localparam logic [ADDR_WIDTH:0] MOD_X     = (ADDR_WIDTH+1)'(ADDR_MAX + 1);
  localparam logic [ADDR_WIDTH:0] STEP_FAST = (ADDR_WIDTH+1)'(2 ** FAST_SHIFT);
  localparam logic [ADDR_WIDTH:0] STEP_ONE  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {REST, INC1, INC2, INC3, DEC1, DEC2, DEC3, ERR} qstate_t;

  logic                                a_p0, a_p1, b_p0, b_p1;
  logic                                ctr_p0, ctr_p1, ctr_p2;
  logic [1:0]                          ab_p1;
  qstate_t                             state, state_nxt;
  logic                                ev_inc, ev_dec, press;
  logic [CHANNELS-1:0]                 hit;
  logic [CHANNELS-1:0][ADDR_WIDTH-1:0] regs;
  logic [ADDR_WIDTH-1:0]               addr_mux;
  logic                                inc_pulse_q, dec_pulse_q;
  logic [ADDR_WIDTH:0]                 step;

  function automatic logic [ADDR_WIDTH-1:0] step_up(input logic [ADDR_WIDTH-1:0] v,
                                                    input logic [ADDR_WIDTH:0]   s);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, v} + s;
    if (sum > MAX_X) begin
      if (WRAP != 0) return ADDR_WIDTH'(sum - MOD_X);
      else           return ADDR_WIDTH'(MAX_X);
    end
    return ADDR_WIDTH'(sum);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] step_dn(input logic [ADDR_WIDTH-1:0] v,
                                                    input logic [ADDR_WIDTH:0]   s);
    logic [ADDR_WIDTH:0] vx;
    vx = {1'b0, v};
    if (vx < s) begin
      if (WRAP != 0) return ADDR_WIDTH'(vx + MOD_X - s);
      else           return '0;
    end
    return ADDR_WIDTH'(vx - s);
  endfunction

  assign ab_p1 = {a_p1, b_p1};
  assign press = ctr_p1 & ~ctr_p2;
  assign step  = bus.fast ? STEP_FAST : STEP_ONE;

  // Decode stage: each state expects one AB code; a one-bit change steps
  // forward or back, a two-bit change is a skipped phase and goes to ERR.
  always_comb begin
    state_nxt = state;
    ev_inc    = 1'b0;
    ev_dec    = 1'b0;
    case (state)
      REST: case (ab_p1)
        2'b01:   state_nxt = INC1;
        2'b10:   state_nxt = DEC1;
        2'b11:   state_nxt = ERR;
        default: state_nxt = REST;
      endcase
      INC1: case (ab_p1)
        2'b11:   state_nxt = INC2;
        2'b00:   state_nxt = REST;
        2'b10:   state_nxt = ERR;
        default: state_nxt = INC1;
      endcase
      INC2: case (ab_p1)
        2'b10:   state_nxt = INC3;
        2'b01:   state_nxt = INC1;
        2'b00:   state_nxt = ERR;
        default: state_nxt = INC2;
      endcase
      INC3: case (ab_p1)
        2'b00:   begin state_nxt = REST; ev_inc = 1'b1; end
        2'b11:   state_nxt = INC2;
        2'b01:   state_nxt = ERR;
        default: state_nxt = INC3;
      endcase
      DEC1: case (ab_p1)
        2'b11:   state_nxt = DEC2;
        2'b00:   state_nxt = REST;
        2'b01:   state_nxt = ERR;
        default: state_nxt = DEC1;
      endcase
      DEC2: case (ab_p1)
        2'b01:   state_nxt = DEC3;
        2'b10:   state_nxt = DEC1;
        2'b00:   state_nxt = ERR;
        default: state_nxt = DEC2;
      endcase
      DEC3: case (ab_p1)
        2'b00:   begin state_nxt = REST; ev_dec = 1'b1; end
        2'b11:   state_nxt = DEC2;
        2'b10:   state_nxt = ERR;
        default: state_nxt = DEC3;
      endcase
      default: state_nxt = (ab_p1 == 2'b00) ? REST : ERR;
    endcase
  end

  always_comb begin
    hit      = '0;
    addr_mux = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      hit[ch] = (32'(bus.sel) == ch);
      if (hit[ch]) addr_mux = regs[ch];
    end
  end

  // Sync stages p0/p1 (p2 holds previous press level); update stage on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0        <= 1'b0;
      a_p1        <= 1'b0;
      b_p0        <= 1'b0;
      b_p1        <= 1'b0;
      ctr_p0      <= 1'b0;
      ctr_p1      <= 1'b0;
      ctr_p2      <= 1'b0;
      state       <= REST;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      regs        <= '0;
    end else begin
      a_p0        <= bus.rot_a;
      a_p1        <= a_p0;
      b_p0        <= bus.rot_b;
      b_p1        <= b_p0;
      ctr_p0      <= bus.rot_ctr;
      ctr_p1      <= ctr_p0;
      ctr_p2      <= ctr_p1;
      state       <= state_nxt;
      inc_pulse_q <= ev_inc;
      dec_pulse_q <= ev_dec;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (hit[ch]) begin
          if (press)       regs[ch] <= '0;
          else if (ev_inc) regs[ch] <= step_up(regs[ch], step);
          else if (ev_dec) regs[ch] <= step_dn(regs[ch], step);
        end
      end
    end
  end

  assign bus.addr      = addr_mux;
  assign bus.addr_all  = regs;
  assign bus.inc_pulse = inc_pulse_q;
  assign bus.dec_pulse = dec_pulse_q;

endmodule
